// File: rtl/fp16_norm_round.sv
// Normalises and rounds a raw half-precision product to an IEEE binary16 result
// using a multi-cycle shift FSM (one shift per cycle) and round-to-nearest-even.
module fp16_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [21:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_flags
);

  typedef enum logic [2:0] {StIdle, StNorm, StDenorm, StRound, StDone} state_e;

  state_e             state_q, state_d;
  logic        [21:0] mant_q, mant_d;
  logic signed [7:0]  exp_q, exp_d;
  logic               sticky_q, sticky_d;
  logic               sign_q, sign_d;
  logic               zero_q, zero_d;
  logic        [3:0]  dcnt_q, dcnt_d;
  logic        [15:0] result_q, result_d;
  logic        [2:0]  flags_q, flags_d;

  logic               rnd_l, rnd_g, rnd_s, rnd_up, rnd_hidden, rnd_inexact;
  logic        [11:0] rnd_sig;
  logic signed [7:0]  rnd_exp;
  logic        [9:0]  rnd_frac;
  logic        [15:0] rnd_result;
  logic        [2:0]  rnd_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mant_q   <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      dcnt_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      dcnt_q   <= dcnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Rounding datapath, evaluated from the working registers while in ROUND.
  always_comb begin
    rnd_l       = mant_q[10];
    rnd_g       = mant_q[9];
    rnd_s       = (|mant_q[8:0]) | sticky_q;
    rnd_up      = rnd_g & (rnd_l | rnd_s);
    rnd_sig     = {1'b0, mant_q[20:10]} + {11'd0, rnd_up};
    rnd_exp     = exp_q + (rnd_sig[11] ? 8'sd1 : 8'sd0);
    rnd_hidden  = rnd_sig[11] | rnd_sig[10];
    rnd_frac    = rnd_sig[11] ? 10'd0 : rnd_sig[9:0];
    rnd_inexact = rnd_g | rnd_s;
    rnd_result  = {sign_q, 15'd0};
    rnd_flags   = 3'b000;
    if (zero_q || rnd_sig == 12'd0) begin
      rnd_result = {sign_q, 15'd0};
      rnd_flags  = 3'b000;
    end else if (rnd_hidden && rnd_exp >= 8'sd31) begin
      rnd_result = {sign_q, 5'h1F, 10'd0};
      rnd_flags  = 3'b101;
    end else if (rnd_hidden) begin
      rnd_result = {sign_q, rnd_exp[4:0], rnd_frac};
      rnd_flags  = {2'b00, rnd_inexact};
    end else begin
      rnd_result = {sign_q, 5'd0, rnd_frac};
      rnd_flags  = {1'b0, rnd_inexact, rnd_inexact};
    end
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    dcnt_d   = dcnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = {in_exp[6], in_exp};
          mant_d   = in_mant;
          zero_d   = in_zero;
          sticky_d = 1'b0;
          dcnt_d   = '0;
          state_d  = StNorm;
        end
      end
      StNorm: begin
        if (zero_q || mant_q == 22'd0) begin
          zero_d  = 1'b1;
          state_d = StRound;
        end else if (mant_q[21]) begin
          mant_d   = {1'b0, mant_q[21:1]};
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 8'sd1;
        end else if (!mant_q[20] && exp_q > 8'sd1) begin
          mant_d = {mant_q[20:0], 1'b0};
          exp_d  = exp_q - 8'sd1;
        end else if (exp_q < 8'sd1) begin
          state_d = StDenorm;
        end else begin
          state_d = StRound;
        end
      end
      StDenorm: begin
        mant_d   = {1'b0, mant_q[21:1]};
        sticky_d = sticky_q | mant_q[0];
        exp_d    = exp_q + 8'sd1;
        dcnt_d   = dcnt_q + 4'd1;
        if (exp_q == 8'sd0) begin
          state_d = StRound;
        end else if (dcnt_q == 4'd11) begin
          // Too small to reach the subnormal range: everything left is sticky.
          mant_d   = '0;
          sticky_d = 1'b1;
          state_d  = StRound;
        end
      end
      StRound: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp16_norm_round.sv
// Self-checking bench: exact-arithmetic reference model for result, flags and latency,
// directed literal cases, backpressure, reset-abort and randomized transactions.
module tb_fp16_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;

  fp16_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: value = m * 2^(e-35); round exactly to binary16 with RNE.
  function automatic void model(input logic s, input logic [6:0] ein, input logic [21:0] m,
                                input logic z, output logic [15:0] res, output logic [2:0] fl,
                                output int lat);
    int e, p, ex, nsh, k, te, q, sh, ef;
    longint mv, r, rem, half;
    logic inex, ovf;
    e   = int'($signed(ein));
    res = {s, 15'h0};
    fl  = 3'b000;
    lat = 2;
    if (z || m == 22'h0) return;
    p = 21;
    while (m[p] == 1'b0) p--;
    // Cycle cost: normalising shifts plus subnormal shifts (capped at 12).
    ex  = e;
    nsh = 0;
    if (p == 21) begin
      nsh = 1;
      ex  = e + 1;
    end else if (ex > 1) begin
      k   = (20 - p < ex - 1) ? 20 - p : ex - 1;
      nsh = k;
      ex  = ex - k;
    end
    if (ex < 1) nsh += (1 - ex > 12) ? 12 : 1 - ex;
    lat = 2 + nsh;
    te = p + e - 35;
    q  = (te + 15 >= 1) ? te - 10 : -24;
    sh = q - (e - 35);
    mv = longint'(m);
    if (sh <= 0) begin
      r    = mv << (-sh);
      inex = 1'b0;
    end else if (sh > 40) begin
      r    = 0;
      inex = 1'b1;
    end else begin
      r    = mv >> sh;
      rem  = mv - (r << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && r[0])) r++;
      inex = (rem != 0);
    end
    if (r == 0) return;
    if (r >= 2048) begin
      r = r >> 1;
      q++;
    end
    ovf = 1'b0;
    ef  = (r < 1024) ? 0 : q + 25;
    if (ef >= 31) begin
      ovf  = 1'b1;
      inex = 1'b1;
      res  = {s, 5'h1F, 10'h0};
    end else begin
      res = {s, ef[4:0], r[9:0]};
    end
    fl = {ovf, inex && (ef == 0), inex};
  endfunction

  task automatic run_txn(input logic s, input logic [6:0] e, input logic [21:0] m, input logic z,
                         input int hold, input string name, input bit has_lit,
                         input logic [15:0] lit_res, input logic [2:0] lit_fl, input int lit_lat);
    logic [15:0] m_res, held_res;
    logic [2:0]  m_fl, held_fl;
    int          m_lat, lat, w;
    model(s, e, m, z, m_res, m_fl, m_lat);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_zero  = z;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, m_lat);
    chk({name, " result"}, {16'd0, out_result}, {16'd0, m_res});
    chk({name, " flags"}, {29'd0, out_flags}, {29'd0, m_fl});
    if (has_lit) begin
      chk({name, " literal latency"}, lat, lit_lat);
      chk({name, " literal result"}, {16'd0, out_result}, {16'd0, lit_res});
      chk({name, " literal flags"}, {29'd0, out_flags}, {29'd0, lit_fl});
    end
    held_res = out_result;
    held_fl  = out_flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " held state"}, {12'd0, out_valid, in_ready, out_flags, out_result},
          {12'd0, 1'b1, 1'b0, held_fl, held_res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [21:0] rm;
    logic [6:0]  re;
    bit          seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset state", {11'd0, in_ready, out_valid, out_flags, out_result}, {11'd0, 1'b1, 20'd0});

    run_txn(1'b0, 7'd15, 22'h100000, 1'b0, 0, "one", 1'b1, 16'h3C00, 3'b000, 2);
    run_txn(1'b0, 7'd15, 22'h240000, 1'b0, 0, "two25", 1'b1, 16'h4080, 3'b000, 3);
    run_txn(1'b0, 7'd15, 22'h100200, 1'b0, 0, "tie_even", 1'b1, 16'h3C00, 3'b001, 2);
    run_txn(1'b0, 7'd15, 22'h100600, 1'b0, 0, "tie_up", 1'b1, 16'h3C02, 3'b001, 2);
    run_txn(1'b1, 7'd30, 22'h300000, 1'b0, 0, "overflow", 1'b1, 16'hFC00, 3'b101, 3);
    run_txn(1'b0, 7'd0, 22'h100000, 1'b0, 0, "subnormal", 1'b1, 16'h0200, 3'b000, 3);
    run_txn(1'b1, 7'd20, 22'h155555, 1'b1, 0, "zero_in", 1'b1, 16'h8000, 3'b000, 2);
    run_txn(1'b0, 7'd15, 22'h100000, 1'b0, 5, "backpressure", 1'b1, 16'h3C00, 3'b000, 2);

    // Abort mid-NORM (long left-shift chain): no output may appear.
    in_sign  = 1'b0;
    in_exp   = 7'd40;
    in_mant  = 22'h000001;
    in_zero  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    chk("abort ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no output", {31'd0, seen}, 32'd0);
    run_txn(1'b0, 7'd15, 22'h100000, 1'b0, 0, "after_abort", 1'b1, 16'h3C00, 3'b000, 2);

    for (int n = 0; n < 400; n++) begin
      rm = 22'($urandom) & (22'h3FFFFF >> $urandom_range(0, 21));
      re = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 40)) : 7'($urandom_range(0, 127));
      run_txn(1'($urandom), re, rm, ($urandom_range(0, 15) == 0), $urandom_range(0, 2),
              "random", 1'b0, 16'h0, 3'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
